// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M mul/div/divu/rem/remu execution unit
// Ports: clk, reset (sync active-high); valid_in/ready_in handshake with op, a, b;
//   flush aborts in-flight work; out_valid pulses once with the registered 64-bit result.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier instead of 64-cycle shift-add.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif
module muldiv_unit (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [`ALUOP_WIDTH-1:0] op,
  input  logic [63:0]             a,
  input  logic [63:0]             b,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [63:0]             result
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, x_q, x_d, y_q, y_d, result_q, result_d;
  logic isrem_q, isrem_d, negq_q, negq_d, negr_q, negr_d;
  logic is_mul, is_sgn, is_rem, is_div, accept, ovf, ge;
  logic [63:0] abs_a, abs_b, mul_next, rnext, qnext, fin;
  logic [64:0] rsh, rdiff;
  assign ready_in = state_q == IDLE;
  assign out_valid = state_q == DONE && !flush;
  assign result = result_q;
  // acc holds the product sum or partial remainder; x the multiplicand or divisor;
  // y the multiplier or the dividend bits shifting out as quotient bits shift in.
  always_comb begin
    is_mul = op == `ALUOP_WIDTH'(15);
    is_sgn = op == `ALUOP_WIDTH'(16) || op == `ALUOP_WIDTH'(18);
    is_rem = op == `ALUOP_WIDTH'(18) || op == `ALUOP_WIDTH'(19);
    is_div = is_sgn || op == `ALUOP_WIDTH'(17) || op == `ALUOP_WIDTH'(19);
    accept = valid_in && ready_in && !flush && (is_mul || is_div);
    ovf = is_sgn && a == 64'h8000_0000_0000_0000 && b == '1;
    abs_a = is_sgn && a[63] ? -a : a;
    abs_b = is_sgn && b[63] ? -b : b;
    mul_next = acc_q + (y_q[0] ? x_q : 64'd0);
    rsh = {acc_q, y_q[63]};
    rdiff = rsh - {1'b0, x_q};
    ge = rsh >= {1'b0, x_q};
    rnext = ge ? rdiff[63:0] : rsh[63:0];
    qnext = {y_q[62:0], ge};
    fin = isrem_q ? (negr_q ? -rnext : rnext) : (negq_q ? -qnext : qnext);
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    x_d = x_q;
    y_d = y_q;
    result_d = result_q;
    isrem_d = isrem_q;
    negq_d = negq_q;
    negr_d = negr_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d = 6'd63;
        isrem_d = is_rem;
        negq_d = is_sgn && (a[63] ^ b[63]);
        negr_d = is_sgn && a[63];
        acc_d = '0;
        if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = DONE;
          result_d = a * b;
`else
          state_d = MUL;
          x_d = a;
          y_d = b;
`endif
        end else if (b == '0) begin
          state_d = DONE;
          result_d = is_rem ? a : '1;
        end else if (ovf) begin
          state_d = DONE;
          result_d = is_rem ? '0 : a;
        end else begin
          state_d = DIV;
          x_d = abs_b;
          y_d = abs_a;
        end
      end
      MUL: begin
        acc_d = mul_next;
        x_d = {x_q[62:0], 1'b0};
        y_d = y_q >> 1;
        cnt_d = cnt_q - 6'd1;
        state_d = cnt_q == '0 ? DONE : MUL;
        result_d = cnt_q == '0 ? mul_next : result_q;
      end
      DIV: begin
        acc_d = rnext;
        y_d = qnext;
        cnt_d = cnt_q - 6'd1;
        state_d = cnt_q == '0 ? DONE : DIV;
        result_d = cnt_q == '0 ? fin : result_q;
      end
      DONE: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
      result_q <= '0;
      isrem_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      x_q <= x_d;
      y_q <= y_d;
      result_q <= result_d;
      isrem_q <= isrem_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
endmodule
